// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
// Holds the forward-mux encodings, the shadow stage record and the match helpers.
package cpu_ctrl_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   localparam int REC_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REC_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
      logic [REC_AW-1:0] rs1;
      logic [REC_AW-1:0] rs2;
      logic              rs1_used;
      logic              rs2_used;
   } stage_rec_t;

   // x0 is hardwired zero, so a write to it never produces a forwardable value.
   function automatic logic writes_reg(input stage_rec_t r, input logic [REC_AW-1:0] rs);
      return r.valid & r.regwrite & (r.rd != '0) & (r.rd == rs);
   endfunction

   // Younger producer (EX/MEM) wins over the older one (MEM/WB).
   function automatic logic [1:0] fwd_sel(input stage_rec_t exmem, input stage_rec_t memwb,
                                          input logic [REC_AW-1:0] rs, input logic used);
      if (!used)                return FWD_RF;
      if (writes_reg(exmem, rs)) return FWD_EXMEM;
      if (writes_reg(memwb, rs)) return FWD_MEMWB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: ID decode fields, branch outcome,
// forward selects, stall/flush controls and event counters.
interface fwd_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic              id_rs1_used_i;
   logic              id_rs2_used_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_regwrite_i;
   logic              id_memread_i;
   logic              ex_branch_taken_i;
   logic [1:0]        fwd_a_sel_o;
   logic [1:0]        fwd_b_sel_o;
   logic              stall_o;
   logic              flush_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  flush_cnt_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
             id_rd_i, id_regwrite_i, id_memread_i, ex_branch_taken_i,
      input  fwd_a_sel_o, fwd_b_sel_o, stall_o, flush_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
             id_rd_i, id_regwrite_i, id_memread_i, ex_branch_taken_i,
      output fwd_a_sel_o, fwd_b_sel_o, stall_o, flush_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/ctrl_stage_reg.sv
// One shadow pipeline record; a bubble loads an all-zero (invalid) record.
module ctrl_stage_reg
   import cpu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       bubble,
   input  stage_rec_t d,
   output stage_rec_t q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         q <= '0;
      else if (bubble) q <= '0;
      else             q <= d;
   end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects, load-use stall and taken-branch flush,
// driven from shadow copies of the ID/EX, EX/MEM and MEM/WB records.
module fwd_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input logic              clk_i,
   input logic              rst_i,
   fwd_hazard_ctrl_if.slave bus
);
   stage_rec_t       id_rec, id_ex, ex_mem, mem_wb;
   logic             load_use, stall, flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   if (REG_AW != REC_AW) begin : g_aw_check
      $error("REG_AW must equal cpu_ctrl_pkg::REC_AW");
   end

   assign id_rec = '{valid:    bus.id_valid_i,
                     rd:       bus.id_rd_i,
                     regwrite: bus.id_regwrite_i,
                     memread:  bus.id_memread_i,
                     rs1:      bus.id_rs1_i,
                     rs2:      bus.id_rs2_i,
                     rs1_used: bus.id_rs1_used_i,
                     rs2_used: bus.id_rs2_used_i};

   ctrl_stage_reg u_id_ex  (.clk(clk_i), .rst(rst_i), .bubble(stall | flush), .d(id_rec), .q(id_ex));
   ctrl_stage_reg u_ex_mem (.clk(clk_i), .rst(rst_i), .bubble(1'b0),          .d(id_ex),  .q(ex_mem));
   ctrl_stage_reg u_mem_wb (.clk(clk_i), .rst(rst_i), .bubble(1'b0),          .d(ex_mem), .q(mem_wb));

   // Load result is only available from MEM/WB, so a consumer directly behind it waits one cycle.
   assign load_use = bus.id_valid_i & id_ex.valid & id_ex.memread & (id_ex.rd != '0) &
                     ((bus.id_rs1_used_i & (bus.id_rs1_i == id_ex.rd)) |
                      (bus.id_rs2_used_i & (bus.id_rs2_i == id_ex.rd)));

   // A flush kills the would-be stalled instruction, so it overrides the stall.
   assign flush = bus.ex_branch_taken_i & id_ex.valid;
   assign stall = load_use & ~flush;

   assign bus.stall_o     = stall;
   assign bus.flush_o     = flush;
   assign bus.fwd_a_sel_o = id_ex.valid ? fwd_sel(ex_mem, mem_wb, id_ex.rs1, id_ex.rs1_used) : FWD_RF;
   assign bus.fwd_b_sel_o = id_ex.valid ? fwd_sel(ex_mem, mem_wb, id_ex.rs2, id_ex.rs2_used) : FWD_RF;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;

   // Record fields carried for completeness but not consulted downstream.
   logic unused_rec;
   assign unused_rec = ^{id_ex.regwrite, ex_mem.memread, ex_mem.rs1, ex_mem.rs2,
                         ex_mem.rs1_used, ex_mem.rs2_used, mem_wb.memread, mem_wb.rs1,
                         mem_wb.rs2, mem_wb.rs1_used, mem_wb.rs2_used};
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random instruction streams
// compared each cycle with an in-order pipeline occupancy model.
module tb_fwd_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();
   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

   typedef struct {
      bit v; int rd; bit rw; bit mr; int rs1; bit u1; int rs2; bit u2;
   } ins_t;

   ins_t st[3];   // in-flight instructions: 0 = in EX, 1 = one older, 2 = two older
   ins_t cur, bub;
   bit   taken, e_stall, e_flush;
   int   n_stall, n_flush;
   int   checks = 0, fails = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic ins_t mk(bit v, int rd, bit rw, bit mr, int rs1, bit u1, int rs2, bit u2);
      ins_t i;
      i.v = v; i.rd = rd; i.rw = rw; i.mr = mr; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
      return i;
   endfunction

   function automatic int exp_sel(int rs, bit used);
      if (!st[0].v || !used) return 0;
      if (st[1].v && st[1].rw && st[1].rd != 0 && st[1].rd == rs) return 2;
      if (st[2].v && st[2].rw && st[2].rd != 0 && st[2].rd == rs) return 1;
      return 0;
   endfunction

   task automatic drive(input ins_t i, input bit tk);
      cur = i; taken = tk;
      bus.id_valid_i    = i.v;
      bus.id_rd_i       = i.rd[4:0];
      bus.id_regwrite_i = i.rw;
      bus.id_memread_i  = i.mr;
      bus.id_rs1_i      = i.rs1[4:0];
      bus.id_rs1_used_i = i.u1;
      bus.id_rs2_i      = i.rs2[4:0];
      bus.id_rs2_used_i = i.u2;
      bus.ex_branch_taken_i = tk;
      #1;
   endtask

   // Check the current cycle against the model, then advance one clock.
   task automatic tick();
      e_flush = taken && st[0].v;
      e_stall = !e_flush && cur.v && st[0].v && st[0].mr && st[0].rd != 0 &&
                ((cur.u1 && cur.rs1 == st[0].rd) || (cur.u2 && cur.rs2 == st[0].rd));
      chk("fwd_a", bus.fwd_a_sel_o, exp_sel(st[0].rs1, st[0].u1));
      chk("fwd_b", bus.fwd_b_sel_o, exp_sel(st[0].rs2, st[0].u2));
      chk("stall", bus.stall_o, e_stall);
      chk("flush", bus.flush_o, e_flush);
      chk("stall_cnt", bus.stall_cnt_o, n_stall);
      chk("flush_cnt", bus.flush_cnt_o, n_flush);
      @(posedge clk);
      st[2] = st[1];
      st[1] = st[0];
      st[0] = (e_stall || e_flush) ? bub : cur;
      if (e_stall) n_stall++;
      if (e_flush) n_flush++;
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) st[k] = bub;
      n_stall = 0; n_flush = 0; e_stall = 0; e_flush = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(bub, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   initial begin
      clear_model();
      @(negedge clk);
      // Reset state, with a branch-taken input that must not flush an empty pipe.
      drive(mk(1, 3, 1, 1, 3, 1, 3, 1), 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_fwd_a", bus.fwd_a_sel_o, 0);
      chk("rst_fwd_b", bus.fwd_b_sel_o, 0);
      chk("rst_stall", bus.stall_o, 0);
      chk("rst_flush", bus.flush_o, 0);
      chk("rst_scnt", bus.stall_cnt_o, 0);
      chk("rst_fcnt", bus.flush_cnt_o, 0);
      @(negedge clk);
      do_reset();

      // add x3 then sub reading x3 on rs1
      drive(mk(1, 3, 1, 0, 1, 1, 2, 1), 0); tick();
      drive(mk(1, 7, 1, 0, 3, 1, 4, 1), 0); tick();
      drive(bub, 0);
      chk("tp1_a", bus.fwd_a_sel_o, 2'b10);
      chk("tp1_b", bus.fwd_b_sel_o, 2'b00);
      tick();

      // x3 written twice, reader of x3 on both operands: newest wins
      drive(mk(1, 3, 1, 0, 0, 0, 0, 0), 0); tick();
      drive(mk(1, 3, 1, 0, 0, 0, 0, 0), 0); tick();
      drive(mk(1, 8, 1, 0, 3, 1, 3, 1), 0); tick();
      drive(bub, 0);
      chk("tp2_a", bus.fwd_a_sel_o, 2'b10);
      chk("tp2_b", bus.fwd_b_sel_o, 2'b10);
      tick();

      // load-use on rs2
      do_reset();
      drive(mk(1, 5, 1, 1, 1, 1, 0, 0), 0); tick();
      drive(mk(1, 6, 1, 0, 2, 1, 5, 1), 0);
      chk("tp3_stall", bus.stall_o, 1);
      tick();
      drive(mk(1, 6, 1, 0, 2, 1, 5, 1), 0);
      chk("tp3_stall_once", bus.stall_o, 0);
      tick();
      drive(bub, 0);
      chk("tp3_b", bus.fwd_b_sel_o, 2'b01);
      chk("tp3_scnt", bus.stall_cnt_o, 1);
      tick();

      // x0 is never a source
      drive(mk(1, 0, 1, 0, 0, 0, 0, 0), 0); tick();
      drive(mk(1, 0, 1, 1, 0, 1, 0, 1), 0); tick();
      drive(mk(1, 9, 1, 0, 0, 1, 0, 1), 0);
      chk("tp4_a", bus.fwd_a_sel_o, 2'b00);
      chk("tp4_b", bus.fwd_b_sel_o, 2'b00);
      chk("tp4_stall", bus.stall_o, 0);
      tick();

      // branch taken during a load-use: flush wins
      do_reset();
      drive(mk(1, 5, 1, 1, 0, 0, 0, 0), 0); tick();
      drive(mk(1, 6, 1, 0, 5, 1, 5, 1), 1);
      chk("tp5_flush", bus.flush_o, 1);
      chk("tp5_stall", bus.stall_o, 0);
      tick();
      drive(bub, 1);
      chk("tp5_idex_empty", bus.flush_o, 0);
      chk("tp5_fcnt", bus.flush_cnt_o, 1);
      chk("tp5_scnt", bus.stall_cnt_o, 0);
      tick();

      // async reset during a stall
      do_reset();
      drive(mk(1, 5, 1, 1, 5, 1, 0, 0), 0); tick();
      drive(mk(1, 4, 1, 0, 5, 1, 0, 0), 0);
      chk("tp6_pre", bus.stall_o, 1);
      rst = 1'b1;
      #1;
      chk("tp6_stall_drop", bus.stall_o, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      drive(bub, 0);
      chk("tp6_a", bus.fwd_a_sel_o, 0);
      chk("tp6_b", bus.fwd_b_sel_o, 0);
      chk("tp6_scnt", bus.stall_cnt_o, 0);
      chk("tp6_fcnt", bus.flush_cnt_o, 0);
      tick();

      // random streams; a stalled ID instruction is re-presented until it issues
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         ins_t nx;
         if (e_stall) nx = cur;
         else nx = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3), $urandom_range(0, 3) != 0);
         drive(nx, $urandom_range(0, 7) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
